// File: rtl/picomem_pkg.sv
// picomem_pkg: shared types and constants for the picomem arbiter slice.
package picomem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam logic [31:0] MMIO_OUT_ADDR = 32'h1000_0000;
  localparam logic [31:0] ERR_RDATA     = 32'hDEAD_BEEF;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

endpackage

// File: rtl/picomem_arbiter_if.sv
// picomem_arbiter_if: one picorv32-native memory bus (valid/ready handshake).
// The master side drives the request fields; the slave side answers with ready/rdata.
interface picomem_arbiter_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output valid, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/picomem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way winner select.
// A lone requester always wins; on a tie the fixed mode favours master 0,
// otherwise the master that did not complete last wins.
module rr_pick2
  import picomem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic       idx
);

  // choose the winner for the current request pair
  always_comb begin
    idx = OWNER_M0;
    case (req)
      2'b01:   idx = OWNER_M0;
      2'b10:   idx = OWNER_M1;
      2'b11:   idx = fixed ? OWNER_M0 : ~last;
      default: idx = OWNER_M0;
    endcase
  end

endmodule

// File: rtl/picomem_arbiter.sv
// picomem_arbiter: shares one picorv32-native slave (RAM + MMIO) between the
// core (m0) and a DMA/debug loader (m1), one transaction in flight at a time.
// Optional feature: define ARB_TIMEOUT_EN to add a slave watchdog that
// completes a stuck transfer with ERR_RDATA and raises sticky timeout_err.
module picomem_arbiter
  import picomem_pkg::*;
#(
  parameter int FIXED_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              resetn,
  picomem_arbiter_if.slave  m0,
  picomem_arbiter_if.slave  m1,
  picomem_arbiter_if.master s,
`ifdef ARB_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output logic              busy
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("picomem_arbiter: TIMEOUT_CYCLES must be within 1..65535");
  end

  state_t      state;
  logic        owner;
  logic        last;
  logic [1:0]  req;
  logic        pick;
  logic        own_valid;
  logic        done;
  logic [31:0] rsp_data;

  assign req = {m1.valid, m0.valid};

  rr_pick2 u_pick (
    .req   (req),
    .last  (last),
    .fixed (FIXED_PRIO != 0),
    .idx   (pick)
  );

  assign own_valid = (owner == OWNER_M1) ? m1.valid : m0.valid;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt;
  logic        to_hit;

  // a real slave answer in the expiry cycle takes precedence over the watchdog
  assign to_hit   = (state == OWN) && own_valid && !s.ready && (to_cnt == TO_LAST);
  assign done     = ((state == OWN) && own_valid && s.ready) || to_hit;
  assign rsp_data = s.ready ? s.rdata : ERR_RDATA;

  // watchdog: count OWN cycles without completion, latch a sticky error on expiry
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE) begin
        to_cnt <= '0;
      end else if (!s.ready) begin
        to_cnt <= to_cnt + 16'd1;
      end
      if (to_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign done     = (state == OWN) && own_valid && s.ready;
  assign rsp_data = s.rdata;
`endif

  // slave request is the owner's request, forced quiet outside OWN
  assign s.valid = (state == OWN) && own_valid;
  assign s.addr  = (state != OWN) ? '0 : ((owner == OWNER_M1) ? m1.addr  : m0.addr);
  assign s.wdata = (state != OWN) ? '0 : ((owner == OWNER_M1) ? m1.wdata : m0.wdata);
  assign s.wstrb = (state != OWN) ? '0 : ((owner == OWNER_M1) ? m1.wstrb : m0.wstrb);

  // completion is steered only to the owner; the other master sees zeros
  assign m0.ready = done && (owner == OWNER_M0);
  assign m1.ready = done && (owner == OWNER_M1);
  assign m0.rdata = m0.ready ? rsp_data : '0;
  assign m1.rdata = m1.ready ? rsp_data : '0;

  assign busy = (state == OWN);

  // grant FSM: register the winner in IDLE, hold it until completion or abandonment
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      owner <= OWNER_M0;
      last  <= OWNER_M1;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner <= pick;
            state <= OWN;
          end
        end
        OWN: begin
          if (!own_valid) begin
            state <= IDLE;
          end else if (done) begin
            last  <= owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picomem_arbiter.sv
// tb_picomem_arbiter: directed table vectors, hand-written corner sequences and
// a randomized run against a cycle-level reference model of the arbitration rules.
module tb_picomem_arbiter;
  import picomem_pkg::*;

  localparam int          TO = 8;
  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] D0 = 32'hAAAA_5555;
  localparam logic [3:0]  W0 = 4'h0;
  localparam logic [31:0] D1 = 32'h0000_0041;
  localparam logic [3:0]  W1 = 4'b0001;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic busy_rr, busy_fp;
`ifdef ARB_TIMEOUT_EN
  logic terr_rr, terr_fp;
`endif

  int total = 0;
  int bad = 0;

  picomem_arbiter_if r0 ();
  picomem_arbiter_if r1 ();
  picomem_arbiter_if rs ();
  picomem_arbiter_if f0 ();
  picomem_arbiter_if f1 ();
  picomem_arbiter_if fs ();

  always #5 clk = ~clk;

  picomem_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(TO)) dut_rr (
    .clk(clk), .resetn(resetn), .m0(r0), .m1(r1), .s(rs),
`ifdef ARB_TIMEOUT_EN
    .timeout_err(terr_rr),
`endif
    .busy(busy_rr)
  );

  picomem_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(TO)) dut_fp (
    .clk(clk), .resetn(resetn), .m0(f0), .m1(f1), .s(fs),
`ifdef ARB_TIMEOUT_EN
    .timeout_err(terr_fp),
`endif
    .busy(busy_fp)
  );

  typedef struct {
    logic        v0;
    logic        v1;
    int          prime;
    logic [31:0] ea;
    logic [31:0] ed;
    logic [3:0]  ew;
  } vec_t;

  vec_t tbl[6];

  logic [31:0] ad[2];
  logic [31:0] wd[2];
  logic [3:0]  ws[2];
  bit          got[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] resp(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // drive a fixed directed transaction on one RR master
  task automatic set_m(input int i, input logic v);
    if (i == 0) begin
      r0.valid = v; r0.addr = A0; r0.wdata = D0; r0.wstrb = W0;
    end else begin
      r1.valid = v; r1.addr = MMIO_OUT_ADDR; r1.wdata = D1; r1.wstrb = W1;
    end
  endtask

  // drive the current random transaction on one RR master
  task automatic drv(input int i, input logic v);
    if (i == 0) begin
      r0.valid = v; r0.addr = ad[0]; r0.wdata = wd[0]; r0.wstrb = ws[0];
    end else begin
      r1.valid = v; r1.addr = ad[1]; r1.wdata = wd[1]; r1.wstrb = ws[1];
    end
  endtask

  // complete one lone transfer by master `who` so that it becomes the last completer
  task automatic prime(input int who);
    int n;
    set_m(who, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rs.valid && n < 8);
    chk1("prime_grant", rs.valid, 1'b1);
    rs.ready = 1'b1;
    rs.rdata = 32'h0;
    @(posedge clk);
    #1;
    rs.ready = 1'b0;
    set_m(who, 1'b0);
  endtask

  // serve whatever RR requests are still outstanding
  task automatic drain();
    int n;
    logic g0, g1;
    n = 0;
    while ((r0.valid || r1.valid) && n < 20) begin
      @(negedge clk);
      n++;
      if (rs.valid) begin
        rs.ready = 1'b1;
        #1;
        g0 = r0.ready;
        g1 = r1.ready;
        @(posedge clk);
        #1;
        rs.ready = 1'b0;
        if (g0) r0.valid = 1'b0;
        if (g1) r1.valid = 1'b0;
      end
    end
    chk1("drain_done", r0.valid | r1.valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  win;
    bit  mfree;
    int  mown, mlast, k;
    logic vo, exp_done;
    logic [31:0] exp_rd;
    logic [1:0] exp_own [4];

    tbl[0] = '{v0: 1'b1, v1: 1'b1, prime: 0, ea: MMIO_OUT_ADDR, ed: D1, ew: W1};
    tbl[1] = '{v0: 1'b1, v1: 1'b1, prime: 1, ea: A0,            ed: D0, ew: W0};
    tbl[2] = '{v0: 1'b0, v1: 1'b1, prime: 1, ea: MMIO_OUT_ADDR, ed: D1, ew: W1};
    tbl[3] = '{v0: 1'b1, v1: 1'b0, prime: 0, ea: A0,            ed: D0, ew: W0};
    tbl[4] = '{v0: 1'b1, v1: 1'b0, prime: 1, ea: A0,            ed: D0, ew: W0};
    tbl[5] = '{v0: 1'b0, v1: 1'b1, prime: 0, ea: MMIO_OUT_ADDR, ed: D1, ew: W1};
    exp_own[0] = 2'd0; exp_own[1] = 2'd1; exp_own[2] = 2'd0; exp_own[3] = 2'd1;

    set_m(0, 1'b0); set_m(1, 1'b0);
    f0.valid = 1'b0; f0.addr = A0; f0.wdata = D0; f0.wstrb = W0;
    f1.valid = 1'b0; f1.addr = MMIO_OUT_ADDR; f1.wdata = D1; f1.wstrb = W1;
    fs.ready = 1'b0; fs.rdata = '0;

    // reset state: outputs quiet even with a request and a slave answer present
    resetn = 1'b0;
    r0.valid = 1'b1;
    rs.ready = 1'b1;
    rs.rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_busy", busy_rr, 1'b0);
    chk1("rst_svalid", rs.valid, 1'b0);
    chk1("rst_m0ready", r0.ready, 1'b0);
    chk1("rst_m1ready", r1.ready, 1'b0);
    chk("rst_m0rdata", r0.rdata, 32'h0);
    chk("rst_m1rdata", r1.rdata, 32'h0);
    chk("rst_saddr", rs.addr, 32'h0);
    chk1("rst_fp_busy", busy_fp, 1'b0);
    r0.valid = 1'b0;
    rs.ready = 1'b0;
    rs.rdata = '0;
    cyc();
    resetn = 1'b1;

    // single m0 read, slave answers after two wait cycles
    cyc();
    set_m(0, 1'b1);
    @(negedge clk);
    chk1("rd_idle_svalid", rs.valid, 1'b0);
    cyc();
    @(negedge clk);
    chk1("rd_svalid_n1", rs.valid, 1'b1);
    chk("rd_saddr", rs.addr, A0);
    chk1("rd_busy", busy_rr, 1'b1);
    cyc();
    @(negedge clk);
    chk1("rd_wait_ready", r0.ready, 1'b0);
    cyc();
    rs.ready = 1'b1;
    rs.rdata = 32'h1234_5678;
    @(negedge clk);
    chk1("rd_m0ready", r0.ready, 1'b1);
    chk("rd_m0rdata", r0.rdata, 32'h1234_5678);
    chk1("rd_m1ready", r1.ready, 1'b0);
    chk("rd_m1rdata", r1.rdata, 32'h0);
    cyc();
    set_m(0, 1'b0);
    rs.ready = 1'b0;
    rs.rdata = '0;
    @(negedge clk);
    chk1("rd_after_ready", r0.ready, 1'b0);
    chk1("rd_after_busy", busy_rr, 1'b0);
    cyc();

    // table: arbitration decision given the last completer and the request pair
    for (int i = 0; i < 6; i++) begin
      prime(tbl[i].prime);
      set_m(0, tbl[i].v0);
      set_m(1, tbl[i].v1);
      r0.addr = A0;
      @(negedge clk);
      chk1("vec_gap", rs.valid, 1'b0);
      cyc();
      @(negedge clk);
      chk("vec_saddr", rs.addr, tbl[i].ea);
      chk("vec_swdata", rs.wdata, tbl[i].ed);
      chk("vec_swstrb", {28'h0, rs.wstrb}, {28'h0, tbl[i].ew});
      win = (tbl[i].ea == MMIO_OUT_ADDR);
      rs.ready = 1'b1;
      rs.rdata = 32'hC0DE_0000 | i;
      #1;
      chk1("vec_win_ready", win ? r1.ready : r0.ready, 1'b1);
      chk1("vec_lose_ready", win ? r0.ready : r1.ready, 1'b0);
      chk("vec_win_rdata", win ? r1.rdata : r0.rdata, 32'hC0DE_0000 | i);
      cyc();
      rs.ready = 1'b0;
      set_m(win ? 1 : 0, 1'b0);
      drain();
      cyc();
    end

    // round robin with both masters continuously requesting
    set_m(0, 1'b1);
    set_m(1, 1'b1);
    for (int t = 0; t < 4; t++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rs.valid && n < 8);
      chk("b2b_latency", n, (t == 0) ? 2 : 1);
      chk("b2b_owner", {31'h0, rs.addr == MMIO_OUT_ADDR}, {30'h0, exp_own[t]});
      rs.ready = 1'b1;
      cyc();
      rs.ready = 1'b0;
      if (t == 3) begin
        set_m(0, 1'b0);
        set_m(1, 1'b0);
      end
      @(negedge clk);
      chk1("b2b_gap", rs.valid, 1'b0);
    end
    cyc();

    // reset asserted mid-transfer while the slave is answering
    set_m(1, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rs.valid && n < 8);
    rs.ready = 1'b1;
    rs.rdata = 32'h5555_0000;
    #1;
    chk1("rstmid_pre_ready", r1.ready, 1'b1);
    resetn = 1'b0;
    #1;
    chk1("rstmid_svalid", rs.valid, 1'b0);
    chk1("rstmid_busy", busy_rr, 1'b0);
    chk1("rstmid_m0ready", r0.ready, 1'b0);
    chk1("rstmid_m1ready", r1.ready, 1'b0);
    rs.ready = 1'b0;
    set_m(0, 1'b1);
    cyc();
    cyc();
    resetn = 1'b1;
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("rstmid_first_grant", rs.addr, A0);
    drain();
    cyc();

`ifdef ARB_TIMEOUT_EN
    // watchdog: slave never answers
    chk1("to_err_before", terr_rr, 1'b0);
    set_m(0, 1'b1);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy_rr) n++;
      if (r0.ready) break;
    end
    chk("to_cycles", n, TO);
    chk1("to_ready", r0.ready, 1'b1);
    chk("to_rdata", r0.rdata, ERR_RDATA);
    cyc();
    chk1("to_err_set", terr_rr, 1'b1);
    set_m(0, 1'b0);
    @(negedge clk);
    chk1("to_svalid_drop", rs.valid, 1'b0);
    repeat (3) cyc();
    chk1("to_err_sticky", terr_rr, 1'b1);
    chk1("to_fp_err_clear", terr_fp, 1'b0);
`endif

    // fixed priority: m0 wins every round, m1 only after m0 withdraws
    f0.valid = 1'b1;
    f1.valid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!fs.valid && n < 8);
      chk("fp_owner", fs.addr, (t < 3) ? A0 : MMIO_OUT_ADDR);
      chk1("fp_busy", busy_fp, 1'b1);
      fs.ready = 1'b1;
      fs.rdata = 32'hF000_0000 | t;
      #1;
      chk1("fp_m0ready", f0.ready, (t < 3));
      chk1("fp_m1ready", f1.ready, (t == 3));
      cyc();
      fs.ready = 1'b0;
      if (t == 2) f0.valid = 1'b0;
      if (t == 3) f1.valid = 1'b0;
    end

    // randomized run against the rule model, starting from reset
    resetn = 1'b0;
    drv(0, 1'b0);
    drv(1, 1'b0);
    rs.ready = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
    mfree = 1'b1;
    mown = 0;
    mlast = 1;
    k = 0;
    got[0] = 1'b0;
    got[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      for (int i = 0; i < 2; i++) begin
        if (got[i]) begin
          drv(i, 1'b0);
          got[i] = 1'b0;
        end else if (!((i == 0) ? r0.valid : r1.valid)) begin
          if ($urandom_range(1, 0) == 1) begin
            ad[i] = {(i == 0) ? 4'h0 : 4'h2, 28'($urandom)};
            wd[i] = $urandom;
            ws[i] = ($urandom_range(1, 0) == 1) ? 4'($urandom) : 4'h0;
            drv(i, 1'b1);
          end
        end else if ($urandom_range(63, 0) == 0) begin
          drv(i, 1'b0);
        end
      end
      #1;
      rs.ready = rs.valid && ($urandom_range(2, 0) == 0);
      rs.rdata = resp(rs.addr);
      @(negedge clk);
      if (mfree) begin
        chk1("rnd_idle_svalid", rs.valid, 1'b0);
        chk1("rnd_idle_m0ready", r0.ready, 1'b0);
        chk1("rnd_idle_m1ready", r1.ready, 1'b0);
        if (r0.valid || r1.valid) begin
          mown = (r0.valid && r1.valid) ? (1 - mlast) : (r1.valid ? 1 : 0);
          mfree = 1'b0;
          k = 0;
        end
      end else begin
        k++;
        vo = (mown == 1) ? r1.valid : r0.valid;
        chk1("rnd_svalid", rs.valid, vo);
        if (!vo) begin
          chk1("rnd_drop_m0ready", r0.ready, 1'b0);
          chk1("rnd_drop_m1ready", r1.ready, 1'b0);
          mfree = 1'b1;
        end else begin
          chk("rnd_saddr", rs.addr, ad[mown]);
          chk("rnd_swdata", rs.wdata, wd[mown]);
          chk("rnd_swstrb", {28'h0, rs.wstrb}, {28'h0, ws[mown]});
          exp_done = rs.ready;
          exp_rd = resp(ad[mown]);
`ifdef ARB_TIMEOUT_EN
          if (!rs.ready && k == TO) begin
            exp_done = 1'b1;
            exp_rd = ERR_RDATA;
          end
`endif
          chk1("rnd_own_ready", (mown == 1) ? r1.ready : r0.ready, exp_done);
          chk1("rnd_other_ready", (mown == 1) ? r0.ready : r1.ready, 1'b0);
          chk("rnd_other_rdata", (mown == 1) ? r0.rdata : r1.rdata, 32'h0);
          if (exp_done) begin
            chk("rnd_own_rdata", (mown == 1) ? r1.rdata : r0.rdata, exp_rd);
            got[mown] = 1'b1;
            mlast = mown;
            mfree = 1'b1;
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
